// File: rtl/dispenser_controller.sv
// Dispense back end: queues release strobes, drives one motor at a time,
// confirms each drop on the item sensor and latches a jam fault on timeout.
module dispenser_controller #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          LR1,
  input  logic                          LR2,
  input  logic                          LL,
  input  logic                          SENS,
  output logic                          MOT1,
  output logic                          MOT2,
  output logic                          MOTL,
  output logic                          DONE,
  output logic                          OVF,
  output logic                          FAULT,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   PEND
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]  TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]  STL_LAST = 16'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_FAULT
  } state_t;

  state_t        state;
  logic [1:0]    fifo [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    cur;
  logic [15:0]   timer;

  logic       strobe;
  logic [1:0] req;
  logic       pop;
  logic       to_fault;
  logic       push;
  logic       drop;

  always_comb begin
    req = 2'b01;
    priority case (1'b1)
      LL:      req = 2'b11;
      LR2:     req = 2'b10;
      default: req = 2'b01;
    endcase
  end

  assign strobe   = LR1 | LR2 | LL;
  assign pop      = (state == ST_IDLE) && (count != '0);
  assign to_fault = (state == ST_DRIVE) && !SENS && (timer == TMO_LAST);
  assign push     = strobe && !to_fault && (state != ST_FAULT) &&
                    ((count != FULL) || pop);
  assign drop     = strobe && !push;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cur    <= 2'b00;
      timer  <= '0;
      DONE   <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      OVF  <= drop;
      if (push) begin
        fifo[wr_ptr] <= req;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      unique case (state)
        ST_IDLE: begin
          if (count != '0) begin
            cur   <= fifo[rd_ptr];
            timer <= '0;
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (SENS) begin
            timer <= '0;
            DONE  <= 1'b1;
            state <= ST_SETTLE;
          end else if (timer == TMO_LAST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= ST_FAULT;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_SETTLE: begin
          // DONE cycle followed by SETTLE_CYCLES quiet cycles
          if (timer == STL_LAST)
            state <= ST_IDLE;
          else
            timer <= timer + 16'd1;
        end
        ST_FAULT: state <= ST_FAULT;
      endcase
    end
  end

  assign MOT1  = (state == ST_DRIVE) && (cur == 2'b01);
  assign MOT2  = (state == ST_DRIVE) && (cur == 2'b10);
  assign MOTL  = (state == ST_DRIVE) && (cur == 2'b11);
  assign FAULT = (state == ST_FAULT);
  assign BUSY  = (state != ST_IDLE) || (count != '0);
  assign PEND  = count;

endmodule

// File: tb/tb_dispenser_controller.sv
// Scoreboard bench for dispenser_controller: expected motor codes are queued
// at stimulus time and popped as each motor starts.
module tb_dispenser_controller;

  logic       CLK = 1'b0;
  logic       RST, LR1, LR2, LL, SENS;
  logic       MOT1, MOT2, MOTL, DONE, OVF, FAULT, BUSY;
  logic [2:0] PEND;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];
  logic [2:0] prev_mot = 3'b000;

  dispenser_controller #(
    .FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(16),
    .SETTLE_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST(RST), .LR1(LR1), .LR2(LR2), .LL(LL), .SENS(SENS),
    .MOT1(MOT1), .MOT2(MOT2), .MOTL(MOTL), .DONE(DONE), .OVF(OVF),
    .FAULT(FAULT), .BUSY(BUSY), .PEND(PEND)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  function automatic int mot_code();
    if (MOTL) return 3;
    if (MOT2) return 2;
    if (MOT1) return 1;
    return 0;
  endfunction

  // Motor-start monitor, offset from the negedge so directed checks settle
  always begin
    logic [2:0] mot;
    @(negedge CLK);
    #2;
    mot = {MOTL, MOT2, MOT1};
    if ($countones(mot) > 1)
      chk("motor overlap", $countones(mot), 1);
    if (mot != 3'b000 && prev_mot == 3'b000) begin
      if (exp_q.size() == 0)
        chk("unexpected motor", mot_code(), 0);
      else
        chk("motor order", mot_code(), int'(exp_q.pop_front()));
    end
    prev_mot = mot;
  end

  task automatic do_reset();
    RST = 1'b1; LR1 = 1'b0; LR2 = 1'b0; LL = 1'b0; SENS = 1'b0;
    step();
    RST = 1'b0;
  endtask

  task automatic wait_motor(input string tag);
    int n = 0;
    while (!(MOT1 || MOT2 || MOTL) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk({tag, " motor timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY && n < 100) begin
      step();
      n++;
    end
    chk({tag, " idle"}, BUSY, 0);
  endtask

  task automatic serve(input string tag, input int pend_exp);
    wait_motor(tag);
    chk({tag, " pend"}, PEND, pend_exp);
    step(2);
    SENS = 1'b1;
    step();
    SENS = 1'b0;
    chk({tag, " done"}, DONE, 1);
  endtask

  initial begin
    int n;
    RST = 1'b1; LR1 = 1'b0; LR2 = 1'b0; LL = 1'b0; SENS = 1'b0;
    step(2);
    chk("rst mot", {MOTL, MOT2, MOT1}, 0);
    chk("rst flags", {DONE, OVF, FAULT, BUSY}, 0);
    chk("rst pend", PEND, 0);
    RST = 1'b0;
    step();

    // 1: single LR1, sensor on 4th drive cycle
    LR1 = 1'b1; exp_q.push_back(2'b01);
    step();
    LR1 = 1'b0;
    chk("t1 pend", PEND, 1);
    chk("t1 mot early", MOT1, 0);
    step();
    for (int c = 2; c <= 5; c++) begin
      chk("t1 mot1", MOT1, 1);
      if (c == 5) SENS = 1'b1;
      step();
    end
    SENS = 1'b0;
    chk("t1 done", DONE, 1);
    chk("t1 mot off", MOT1, 0);
    step(4);
    chk("t1 busy c10", BUSY, 1);
    step();
    chk("t1 busy c11", BUSY, 0);
    step(3);

    // 2: LR2, LL, LR1 back to back
    LR2 = 1'b1; exp_q.push_back(2'b10);
    step();
    LR2 = 1'b0; LL = 1'b1; exp_q.push_back(2'b11);
    chk("t2 pend c1", PEND, 1);
    step();
    LL = 1'b0; LR1 = 1'b1; exp_q.push_back(2'b01);
    chk("t2 pend c2", PEND, 1);
    chk("t2 mot2", MOT2, 1);
    step();
    LR1 = 1'b0;
    chk("t2 pend c3", PEND, 2);
    step();
    SENS = 1'b1;
    step();
    SENS = 1'b0;
    chk("t2 done1", DONE, 1);
    serve("t2 second", 1);
    serve("t2 third", 0);
    wait_idle("t2");
    chk("t2 pend end", PEND, 0);

    // 3: six LR1 pulses into a depth-4 queue
    for (int i = 0; i < 6; i++) begin
      LR1 = 1'b1;
      if (i < 5) exp_q.push_back(2'b01);
      step();
    end
    LR1 = 1'b0;
    chk("t3 ovf", OVF, 1);
    chk("t3 pend full", PEND, 4);
    step();
    chk("t3 ovf once", OVF, 0);
    n = 0;
    while (!FAULT && n < 50) begin step(); n++; end
    chk("t3 fault", FAULT, 1);
    chk("t3 flushed", PEND, 0);
    exp_q.delete();
    do_reset();
    chk("t3 reset fault", FAULT, 0);
    step();

    // 4: jam on large product
    LL = 1'b1; exp_q.push_back(2'b11);
    step();
    LL = 1'b0;
    step();
    n = 0;
    while (MOTL && n < 40) begin step(); n++; end
    chk("t4 motl cycles", n, 16);
    chk("t4 fault", FAULT, 1);
    chk("t4 pend", PEND, 0);
    step(5);
    chk("t4 fault sticky", FAULT, 1);
    LR2 = 1'b1;
    step();
    LR2 = 1'b0;
    chk("t4 ovf", OVF, 1);
    step(5);
    chk("t4 no motor", {MOTL, MOT2, MOT1}, 0);
    chk("t4 still fault", FAULT, 1);
    do_reset();
    step();

    // 5: reset mid-drive with two queued
    LR2 = 1'b1; exp_q.push_back(2'b10);
    step();
    LR2 = 1'b0; LR1 = 1'b1;
    step();
    LR1 = 1'b1;
    step();
    LR1 = 1'b0;
    chk("t5 mot2", MOT2, 1);
    chk("t5 pend", PEND, 2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t5 mot off", {MOTL, MOT2, MOT1}, 0);
    chk("t5 pend clr", PEND, 0);
    chk("t5 busy", BUSY, 0);
    SENS = 1'b1;
    step();
    SENS = 1'b0;
    chk("t5 no done", DONE, 0);
    step();
    chk("t5 no done2", DONE, 0);
    step(3);

    // 6: simultaneous LR1+LL, sensor on last drive cycle
    LR1 = 1'b1; LL = 1'b1; exp_q.push_back(2'b11);
    step();
    LR1 = 1'b0; LL = 1'b0;
    chk("t6 pend", PEND, 1);
    chk("t6 no ovf", OVF, 0);
    step();
    chk("t6 motl", MOTL, 1);
    chk("t6 mot1", MOT1, 0);
    step(15);
    chk("t6 last drive", MOTL, 1);
    SENS = 1'b1;
    step();
    SENS = 1'b0;
    chk("t6 done", DONE, 1);
    chk("t6 no fault", FAULT, 0);
    wait_idle("t6");
    chk("t6 fault end", FAULT, 0);
    chk("t6 pend end", PEND, 0);
    step(2);

    chk("scoreboard empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
